// File: rtl/atm_pin_entry.sv
// atm_pin_entry
//   Front-end of the ATM controller. Latches the card's account number on card
//   insertion, collects a 4-digit BCD PIN from the keypad (digits, backspace,
//   clear, enter, cancel), hands acc_num/pin to the authenticator and reacts to
//   its verdict. Too many rejections retain the card and lock until reset.
//
//   Optional feature: define ATM_PIN_TIMEOUT_EN to enable the COLLECT
//   inactivity timer (TIMEOUT_CYCLES). Without it COLLECT waits indefinitely.
//
// Parameters
//   TIMEOUT_CYCLES  inactivity limit in COLLECT, clk cycles (>= 2)
//   MAX_ATTEMPTS    rejected submissions before lock (1..7)
// Ports
//   clk, rst        clock, asynchronous active-low reset
//   card_in         card present level
//   card_acc[3:0]   account number from card
//   key_valid       one-cycle key strobe, key_code[3:0] valid with it
//   auth_done       one-cycle verdict strobe, auth_ok sampled with it
//   acc_num[3:0]    latched account number
//   pin[15:0]       packed BCD PIN, first digit in [15:12]
//   pin_valid       high in SUBMIT
//   digit_count     digits entered (0..4)
//   attempts        rejected submissions this session
//   session_ok      high in SESSION
//   locked          high in LOCKED
//   card_eject      one-cycle eject pulse (coincides with EJECT state)
//   state[2:0]      IDLE=0 COLLECT=1 SUBMIT=2 SESSION=3 EJECT=4 LOCKED=5

module atm_pin_entry #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_ATTEMPTS   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        card_in,
  input  logic [3:0]  card_acc,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        auth_done,
  input  logic        auth_ok,
  output logic [3:0]  acc_num,
  output logic [15:0] pin,
  output logic        pin_valid,
  output logic [2:0]  digit_count,
  output logic [2:0]  attempts,
  output logic        session_ok,
  output logic        locked,
  output logic        card_eject,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_SUBMIT  = 3'd2,
    S_SESSION = 3'd3,
    S_EJECT   = 3'd4,
    S_LOCKED  = 3'd5
  } state_e;

  localparam logic [3:0] K_CLEAR  = 4'hA;
  localparam logic [3:0] K_BSP    = 4'hB;
  localparam logic [3:0] K_ENTER  = 4'hC;
  localparam logic [3:0] K_CANCEL = 4'hD;

  // Parameter sanity, caught at elaboration.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("atm_pin_entry: TIMEOUT_CYCLES must be >= 2");
  end
  if (MAX_ATTEMPTS < 1 || MAX_ATTEMPTS > 7) begin : g_bad_attempts
    $error("atm_pin_entry: MAX_ATTEMPTS must be in 1..7");
  end

  state_e     st;
  logic       card_in_q;
  // Card edges are only honoured once card_in has been seen low since reset,
  // so a card left in the slot across a reset is not re-accepted.
  logic       card_arm;
  logic       key_dig;
  logic       key_acc;    // 0x0..0xD: accepted keys, restart the timer
  logic       tmo_hit;
  logic [2:0] att_nxt;

  assign key_dig = key_valid && (key_code <= 4'd9);
  assign key_acc = key_valid && (key_code <= K_CANCEL);
  assign att_nxt = attempts + 3'd1;
  assign state   = st;

`ifdef ATM_PIN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmr;

  // Held at zero outside COLLECT so every entry to COLLECT starts fresh;
  // saturates at the terminal count instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          tmr <= '0;
    else if (st != S_COLLECT || key_acc) tmr <= '0;
    else if (tmr != TMO_LAST)          tmr <= tmr + 1'b1;
  end

  assign tmo_hit = (st == S_COLLECT) && !key_acc && (tmr == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st          <= S_IDLE;
      card_in_q   <= 1'b0;
      card_arm    <= 1'b0;
      acc_num     <= '0;
      pin         <= '0;
      pin_valid   <= 1'b0;
      digit_count <= '0;
      attempts    <= '0;
      session_ok  <= 1'b0;
      locked      <= 1'b0;
      card_eject  <= 1'b0;
    end else begin
      card_in_q  <= card_in;
      card_eject <= 1'b0;
      if (!card_in) card_arm <= 1'b1;

      case (st)
        S_IDLE: begin
          if (card_in && !card_in_q && card_arm) begin
            acc_num     <= card_acc;
            pin         <= '0;
            digit_count <= '0;
            attempts    <= '0;
            st          <= S_COLLECT;
          end
        end

        S_COLLECT: begin
          // Card removal beats any same-cycle key or timeout.
          if (!card_in) begin
            pin         <= '0;
            digit_count <= '0;
            attempts    <= '0;
            st          <= S_IDLE;
          end else if (key_acc) begin
            if (key_dig) begin
              if (digit_count < 3'd4) begin
                pin         <= {pin[11:0], key_code};
                digit_count <= digit_count + 3'd1;
              end
            end else begin
              case (key_code)
                K_CLEAR: begin
                  pin         <= '0;
                  digit_count <= '0;
                end
                K_BSP: begin
                  if (digit_count != 3'd0) begin
                    pin         <= {4'h0, pin[15:4]};
                    digit_count <= digit_count - 3'd1;
                  end
                end
                K_ENTER: begin
                  if (digit_count == 3'd4) begin
                    pin_valid <= 1'b1;
                    st        <= S_SUBMIT;
                  end
                end
                default: begin  // K_CANCEL
                  pin         <= '0;
                  digit_count <= '0;
                  card_eject  <= 1'b1;
                  st          <= S_EJECT;
                end
              endcase
            end
          end else if (tmo_hit) begin
            pin         <= '0;
            digit_count <= '0;
            card_eject  <= 1'b1;
            st          <= S_EJECT;
          end
        end

        S_SUBMIT: begin
          if (!card_in) begin
            pin         <= '0;
            digit_count <= '0;
            attempts    <= '0;
            pin_valid   <= 1'b0;
            st          <= S_IDLE;
          end else if (auth_done) begin
            pin_valid <= 1'b0;
            if (auth_ok) begin
              session_ok <= 1'b1;
              st         <= S_SESSION;
            end else begin
              attempts <= att_nxt;
              if (att_nxt == 3'(MAX_ATTEMPTS)) begin
                locked <= 1'b1;
                st     <= S_LOCKED;
              end else begin
                pin         <= '0;
                digit_count <= '0;
                st          <= S_COLLECT;
              end
            end
          end
        end

        S_SESSION: begin
          if (!card_in) begin
            pin         <= '0;
            digit_count <= '0;
            attempts    <= '0;
            session_ok  <= 1'b0;
            st          <= S_IDLE;
          end
        end

        S_EJECT: begin
          pin         <= '0;
          digit_count <= '0;
          st          <= S_IDLE;
        end

        S_LOCKED: begin
          // Card retained; only reset leaves this state.
        end

        default: st <= S_IDLE;
      endcase
    end
  end

endmodule
